alu_scheduler: RTL and testbench
================================

// Module: alu_scheduler
// PURPOSE
//  Shares one 256-bit bit-manipulation ALU (PARITY/ROTR/ROTL/POPCOUNT/BITREV) between NUM_REQ requesters.
//  Round-robin arbitration over valid/ready request ports; one op in flight at a time.
//  Holds the ALU opcode/operands stable for the ALU's fixed latency, then captures the result.
//  Returns the result with the requester id on a valid/ready response port. Sits between the clients and the ALU.
// PARAMETERS
//  DATA_WIDTH   256  operand/result width, matches the ALU
//  NUM_REQ      2    number of requesters (>=2)
//  ID_W         1    width of rsp_id; must be >= clog2(NUM_REQ)
//  ALU_LATENCY  2    cycles from operands stable on alu_* to alu_result valid (>=1)
// PORTS
//  clk          in   1                   rising-edge clock
//  rst_n        in   1                   synchronous reset, active-low
//  req_valid    in   NUM_REQ             per-requester request valid
//  req_ready    out  NUM_REQ             per-requester grant; at most one bit high
//  req_opcode   in   NUM_REQ*3           packed opcodes; requester i at [3i+:3]
//  req_a        in   NUM_REQ*DATA_WIDTH  packed operand A
//  req_b        in   NUM_REQ*DATA_WIDTH  packed operand B (shift amount for ROTR/ROTL)
//  alu_opcode   out  3                   to ALU opcode
//  alu_a        out  DATA_WIDTH          to ALU A_in
//  alu_b        out  DATA_WIDTH          to ALU B_in
//  alu_result   in   DATA_WIDTH          from ALU Alu_out
//  rsp_valid    out  1                   response valid
//  rsp_ready    in   1                   response consumer ready
//  rsp_id       out  ID_W                index of the requester served
//  rsp_data     out  DATA_WIDTH          captured ALU result; 0 on error
//  rsp_err      out  1                   1 = illegal opcode (3'b101..3'b111)
//  busy         out  1                   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rr pointer=0; all outputs 0 (alu_* 0, rsp_* 0, busy 0, req_ready 0).
//  FSM IDLE -> EXEC | RESP;  EXEC -> RESP;  RESP -> IDLE.
//  IDLE: req_ready is combinational. Grant the first valid requester at or after the rr pointer, wrapping modulo NUM_REQ.
//   - On the grant edge: latch opcode, A, B, id; pointer <= (winner+1) mod NUM_REQ.
//   - Legal opcode: load counter with ALU_LATENCY, go to EXEC.
//   - Illegal opcode: rsp_err=1, rsp_data=0, go to RESP; the ALU is never driven with it.
//   - No valid request: stay in IDLE.
//  EXEC: alu_* driven from the latched registers, stable for every EXEC cycle. Counter decrements each cycle.
//   - When counter==1: rsp_data <= alu_result, rsp_err <= 0, go to RESP.
//   - EXEC lasts exactly ALU_LATENCY cycles.
//  RESP: rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_valid&rsp_ready, then go to IDLE.
//  Latency: grant in cycle 0 -> rsp_valid high in cycle ALU_LATENCY+1 (legal) or cycle 1 (illegal).
//  req_ready is 0 outside IDLE. A new grant can occur one cycle after a response handshake at the earliest (one bubble).
//  alu_* keep their last latched values outside EXEC. ALU enables derive from the opcode only.
//  Requests are not queued. A requester holds valid and payload until its req_ready; a dropped valid is legal and not served.
//  rst_n low in any state: IDLE next edge; the in-flight op is discarded and no response is issued.
// STRUCTURE
//  alu_pkg: opcode localparams (PARITY=0, ROTR=1, ROTL=2, POPCOUNT=3, BITREV=4), is_legal_op function, FSM state encoding.
//  Sub-module rr_arbiter #(NUM_REQ): req vector + pointer -> one-hot grant + winner index. Combinational.
//  alu_scheduler holds the FSM, latency counter, operand/result registers and packing/unpacking.
// TESTING (ALU model instantiated with ALU_LATENCY=2)
//  1 Reset: hold rst_n=0 3 cycles with req_valid=all-1 -> req_ready=0, rsp_valid=0, busy=0, alu_*=0.
//  2 Single op: req0 POPCOUNT, A=0xFF -> req_ready[0] in cycle 0, rsp_valid in cycle 3, rsp_data=8, rsp_id=0, rsp_err=0.
//  3 Round robin: both valid continuously, rsp_ready=1 -> grant order 0,1,0,1; each grant 4 cycles apart.
//  4 Illegal opcode: req1 opcode 3'b110 -> rsp_valid in cycle 1, rsp_err=1, rsp_data=0, rsp_id=1, alu_opcode unchanged.
//  5 Backpressure: ROTR A=1, B=4 with rsp_ready=0 for 5 cycles -> rsp_data=1<<252 held stable, req_ready=0 throughout.
//  6 Reset mid-EXEC: rst_n=0 in the first EXEC cycle -> IDLE, no rsp_valid. After release, a BITREV A=1 returns 1<<255.

Source files
------------

// File: rtl/alu_scheduler_pkg.sv
// alu_scheduler_pkg
//   Shared definitions for the ALU scheduler: ALU opcode encodings, the
//   opcode legality check and the scheduler FSM state encoding.
package alu_scheduler_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_PARITY   = 3'd0;
  localparam logic [OPC_W-1:0] OP_ROTR     = 3'd1;
  localparam logic [OPC_W-1:0] OP_ROTL     = 3'd2;
  localparam logic [OPC_W-1:0] OP_POPCOUNT = 3'd3;
  localparam logic [OPC_W-1:0] OP_BITREV   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcodes 3'b101..3'b111 have no ALU function behind them.
  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    return (op <= OP_BITREV);
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if
//   Client-side bus of the ALU scheduler.
//   Request side : req_valid/req_ready per requester, packed req_opcode
//                  (requester i at [3i+:3]), packed req_a / req_b
//                  (requester i at [DATA_WIDTH*i +: DATA_WIDTH]).
//   Response side: rsp_valid/rsp_ready, rsp_id, rsp_data, rsp_err.
//   master = the requesters/consumer, slave = the scheduler.
interface alu_scheduler_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int ID_W       = 1
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*3-1:0]          req_opcode;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;

  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first asserted bit of req at or
//   after ptr, wrapping modulo NUM_REQ.
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    highest-priority index for this pick
//   grant     out NUM_REQ  one-hot grant (all zero when req is zero)
//   winner    out IDX_W    index of the granted requester
//   any_grant out 1        some requester was granted
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_grant
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value unassigned, which would infer a latch.
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        winner     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Shares one multi-cycle bit-manipulation ALU between NUM_REQ requesters.
//   One operation is in flight at a time; requesters are served round-robin.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         alu_scheduler_if.slave (request and response handshakes)
//   alu_opcode  opcode to the ALU     (held for the whole EXEC phase)
//   alu_a/b     operands to the ALU   (held for the whole EXEC phase)
//   alu_result  ALU output, sampled on the last EXEC cycle
//   busy        high whenever the FSM is not IDLE
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = 1,
  parameter int ALU_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_scheduler_if.slave        bus,
  output logic [OPC_W-1:0]      alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ALU_LATENCY + 1);

  state_t                state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W-1:0]      next_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic                  any_grant;
  logic [CNT_W-1:0]      lat_cnt;

  logic [OPC_W-1:0]      op_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i] = bus.req_opcode[OPC_W*i +: OPC_W];
    assign a_arr[i]  = bus.req_a[DATA_WIDTH*i +: DATA_WIDTH];
    assign b_arr[i]  = bus.req_b[DATA_WIDTH*i +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(PTR_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  assign next_ptr = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);

  // The grant is combinational in IDLE; rst_n gates it so requesters holding
  // valid during reset are never told they were accepted.
  assign bus.req_ready = (rst_n && state == ST_IDLE) ? grant : '0;
  assign bus.rsp_valid = (state == ST_RESP);
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order. The datapath registers
    // are reset too, because alu_* and rsp_* must read as zero out of reset.
    if (!rst_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      lat_cnt      <= '0;
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_grant) begin
            rr_ptr     <= next_ptr;
            bus.rsp_id <= ID_W'(winner);
            if (is_legal_op(op_arr[winner])) begin
              // The alu_* registers are the operand latch; an illegal opcode
              // never reaches them, so the ALU keeps its previous inputs.
              alu_opcode <= op_arr[winner];
              alu_a      <= a_arr[winner];
              alu_b      <= b_arr[winner];
              lat_cnt    <= CNT_W'(ALU_LATENCY);
              state      <= ST_EXEC;
            end else begin
              bus.rsp_err  <= 1'b1;
              bus.rsp_data <= '0;
              state        <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          lat_cnt <= lat_cnt - CNT_W'(1);
          if (lat_cnt == CNT_W'(1)) begin
            bus.rsp_data <= alu_result;
            bus.rsp_err  <= 1'b0;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler
//   Directed bench for alu_scheduler with a behavioural 2-cycle ALU.
//   Expected responses are queued when a request is granted and popped when
//   the scheduler presents its response.
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  localparam int DW  = 256;
  localparam int NR  = 2;
  localparam int IW  = 1;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     alu_opcode;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_result;
  logic           busy;

  alu_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_W(IW)) bus ();

  alu_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_W       (IW),
    .ALU_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: operands stable from cycle N give a valid result in
  // cycle N+1, i.e. a 2-cycle latency seen from the scheduler's sample point.
  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int s;
    r = '0;
    s = int'(b[7:0]);
    case (op)
      OP_PARITY:   r[0] = ^a;
      OP_ROTR:     for (int i = 0; i < DW; i++) r[i] = a[(i + s) % DW];
      OP_ROTL:     for (int i = 0; i < DW; i++) r[(i + s) % DW] = a[i];
      OP_POPCOUNT: r = DW'($countones(a));
      OP_BITREV:   for (int i = 0; i < DW; i++) r[i] = a[DW-1-i];
      default:     r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) alu_result <= alu_ref(alu_opcode, alu_a, alu_b);

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    bus.req_valid = '0;
    rst_n = 1'b0;
    repeat (cycles) tick;
    rst_n = 1'b1;
  endtask

  // Presents a request on port r, waits (bounded) for its grant, optionally
  // queues the expected response, then crosses the grant edge and drops valid.
  // Returns in the first cycle after the grant.
  task automatic issue(input int r, input logic [2:0] op,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] exp_data, input logic exp_err,
                       input bit push);
    int waited;
    bus.req_opcode[3*r +: 3] = op;
    bus.req_a[DW*r +: DW]    = a;
    bus.req_b[DW*r +: DW]    = b;
    bus.req_valid[r]         = 1'b1;
    #1;
    waited = 0;
    while (!bus.req_ready[r] && waited < 20) begin
      tick;
      waited++;
    end
    check($sformatf("grant_req%0d", r), DW'(bus.req_ready[r]), DW'(1));
    if (push) sb.push_back('{id: IW'(r), data: exp_data, err: exp_err});
    tick;
    bus.req_valid[r] = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid counting cycles since the grant, optionally
  // holds rsp_ready low for 'hold' cycles checking stability, then consumes.
  task automatic collect(input int exp_lat, input int hold);
    int   lat;
    exp_t e;
    lat = 1;
    while (!bus.rsp_valid && lat < 30) begin
      tick;
      lat++;
    end
    check("rsp_latency", DW'(lat), DW'(exp_lat));
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{id: 'x, data: 'x, err: 1'bx};
    if (hold > 0) begin
      bus.req_valid = '1;
      #1;
      for (int k = 0; k < hold; k++) begin
        check("hold_rsp_valid", DW'(bus.rsp_valid), DW'(1));
        check("hold_rsp_data", bus.rsp_data, e.data);
        check("hold_req_ready", DW'(bus.req_ready), DW'(0));
        tick;
      end
      bus.req_valid = '0;
    end
    check("rsp_valid", DW'(bus.rsp_valid), DW'(1));
    check("rsp_id", DW'(bus.rsp_id), DW'(e.id));
    check("rsp_data", bus.rsp_data, e.data);
    check("rsp_err", DW'(bus.rsp_err), DW'(e.err));
    bus.rsp_ready = 1'b1;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp_d;
    logic [NR-1:0] exp_onehot;
    int            grants;
    int            resps;
    int            cyc;
    int            last_g;
    exp_t          e;

    // 1: reset with every requester asserting valid.
    bus.req_opcode = {OP_POPCOUNT, OP_POPCOUNT};
    bus.req_a      = '1;
    bus.req_b      = '0;
    bus.req_valid  = '1;
    bus.rsp_ready  = 1'b1;
    rst_n          = 1'b0;
    repeat (3) tick;
    check("reset_req_ready", DW'(bus.req_ready), DW'(0));
    check("reset_rsp_valid", DW'(bus.rsp_valid), DW'(0));
    check("reset_busy", DW'(busy), DW'(0));
    check("reset_alu_opcode", DW'(alu_opcode), DW'(0));
    check("reset_alu_a", alu_a, '0);
    check("reset_alu_b", alu_b, '0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick;

    // 2: single POPCOUNT from requester 0.
    issue(0, OP_POPCOUNT, DW'(8'hFF), '0, DW'(8), 1'b0, 1'b1);
    check("exec_busy", DW'(busy), DW'(1));
    check("exec_alu_opcode", DW'(alu_opcode), DW'(OP_POPCOUNT));
    check("exec_alu_a", alu_a, DW'(8'hFF));
    collect(LAT + 1, 0);

    // 3: round robin with both requesters continuously valid.
    do_reset(2);
    bus.req_opcode = {OP_ROTL, OP_POPCOUNT};
    bus.req_a      = {DW'(1), DW'(8'h1F)};
    bus.req_b      = {DW'(3), DW'(0)};
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 2'b11;
    #1;
    grants = 0;
    resps  = 0;
    cyc    = 0;
    last_g = 0;
    while ((grants < 4 || resps < 4) && cyc < 60) begin
      if (bus.rsp_valid) begin
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{id: 'x, data: 'x, err: 1'bx};
        check("rr_rsp_id", DW'(bus.rsp_id), DW'(e.id));
        check("rr_rsp_data", bus.rsp_data, e.data);
        check("rr_rsp_err", DW'(bus.rsp_err), DW'(e.err));
        resps++;
      end
      if (bus.req_ready != '0) begin
        exp_onehot = (grants % 2 == 0) ? 2'b01 : 2'b10;
        check("rr_order", DW'(bus.req_ready), DW'(exp_onehot));
        if (grants > 0) check("rr_spacing", DW'(cyc - last_g), DW'(4));
        if (grants % 2 == 0) sb.push_back('{id: IW'(0), data: DW'(5), err: 1'b0});
        else                 sb.push_back('{id: IW'(1), data: DW'(8), err: 1'b0});
        last_g = cyc;
        grants++;
      end
      tick;
      cyc++;
      if (grants == 4) bus.req_valid = '0;
      #1;
    end
    check("rr_grants", DW'(grants), DW'(4));
    check("rr_resps", DW'(resps), DW'(4));

    // 4: illegal opcode from requester 1; ALU inputs stay as last latched.
    issue(1, 3'b110, DW'(16'hBEEF), DW'(9), '0, 1'b1, 1'b1);
    check("illegal_alu_opcode", DW'(alu_opcode), DW'(OP_ROTL));
    check("illegal_alu_b", alu_b, DW'(3));
    collect(1, 0);

    // 5: ROTR with the consumer stalling for 5 cycles.
    bus.rsp_ready = 1'b0;
    exp_d = DW'(1) << 252;
    issue(0, OP_ROTR, DW'(1), DW'(4), exp_d, 1'b0, 1'b1);
    collect(LAT + 1, 5);

    // 6: reset in the first EXEC cycle discards the operation.
    bus.rsp_ready = 1'b1;
    issue(0, OP_POPCOUNT, DW'(8'h0F), '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midreset_busy", DW'(busy), DW'(0));
    for (int k = 0; k < 4; k++) begin
      check("midreset_no_rsp", DW'(bus.rsp_valid), DW'(0));
      tick;
    end
    exp_d = DW'(1) << 255;
    issue(0, OP_BITREV, DW'(1), '0, exp_d, 1'b0, 1'b1);
    collect(LAT + 1, 0);

    check("sb_empty", DW'(sb.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
